lcd_bus_responder: RTL and testbench

- Synthesizable character-LCD model for the 16x2 panel: the display end of the lcd_e/lcd_rs/lcd_rw/sf_d bus that the LCD controller drives.
- Decodes controller write cycles into a 32-byte DDRAM mirror, address counter and display flags. Host logic or a bench reads the mirror back to check on-screen text without the physical panel.
- Sits beside the LCD controller in the stopwatch top level, clocked from the controller clock domain.

---
 rtl/lcd_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_lcd_bus_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_responder.sv
// -----------------------------------------------------------------------------
// lcd_bus_responder
//
// Display-side model of a 16x2 character LCD. It watches the
// lcd_e/lcd_rs/lcd_rw/sf_d bus driven by the LCD controller and decodes each
// write cycle into:
//   - a 32-byte DDRAM mirror (line 1 -> 0..15, line 2 -> 16..31),
//   - the DDRAM address counter,
//   - the display-on flag.
// Host logic reads the mirror back through rd_addr/rd_data to check the
// on-screen text without a physical panel.
//
// Optional feature macro: LCD_BUSY_FLAG_EN
//   Defined   : read cycles are answered on sf_d_out/sf_d_oe.
//               rs=0 returns {busy, addr_cnt}; rs=1 returns the mirror byte at
//               the address counter, and the counter then steps.
//   Undefined : sf_d_out/sf_d_oe are tied low and read cycles are ignored.
//
// Ports
//   clk         in   system clock (controller clock domain)
//   rst         in   synchronous, active-high reset
//   lcd_e       in   enable strobe; a cycle is acted on when it falls
//   lcd_rs      in   0 = command, 1 = data
//   lcd_rw      in   0 = write, 1 = read
//   sf_d[7:0]   in   data bus from the controller
//   sf_d_out    out  read-back data toward the bus (feature build only)
//   sf_d_oe     out  drive enable for sf_d_out
//   rd_addr[4:0] in  mirror index for host read-back
//   rd_data[7:0] out mirror[rd_addr], registered (1 clk latency)
//   busy        out  high while clearing or busy
//   display_on  out  D bit of the last display-control command
//   addr_cnt    out  DDRAM address counter (0x00-0x0F, 0x40-0x4F)
//   err_overrun out  sticky; a write cycle arrived while busy
//
// States
//   ST_CLEAR | fill mirror with spaces, one entry per clk
//   ST_BUSY  | down-counter running, new write cycles are rejected
//   ST_IDLE  | ready to accept controller cycles
// -----------------------------------------------------------------------------
module lcd_bus_responder #(
  parameter int BUSY_CYCLES       = 16,
  parameter int CLEAR_BUSY_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] sf_d,
  output logic [7:0] sf_d_out,
  output logic       sf_d_oe,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       display_on,
  output logic [6:0] addr_cnt,
  output logic       err_overrun
);

  localparam int CNT_MAX = (BUSY_CYCLES > CLEAR_BUSY_CYCLES) ? BUSY_CYCLES
                                                             : CLEAR_BUSY_CYCLES;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] BUSY_LOAD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LOAD = CW'(CLEAR_BUSY_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [7:0]    SPACE_CHAR = 8'h20;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_BUSY  = 2'd1,
    ST_IDLE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Address helpers
  // ---------------------------------------------------------------------------
  // Counter stepping with the two-line wrap: the counter only ever holds
  // 0x00-0x0F or 0x40-0x4F, so the line ends jump to the other line.
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      case (a)
        7'h0F:   r = 7'h40;
        7'h4F:   r = 7'h00;
        default: r = a + 7'd1;
      endcase
    end else begin
      case (a)
        7'h00:   r = 7'h4F;
        7'h40:   r = 7'h0F;
        default: r = a - 7'd1;
      endcase
    end
    return r;
  endfunction

  // 0x00-0x0F -> 0..15, 0x40-0x4F -> 16..31
  function automatic logic [4:0] addr_map(input logic [6:0] a);
    return {a[6], a[3:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Input capture: one 2-flop synchronizer for the whole bus so strobe and
  // data stay aligned, then a falling-edge detect on the synced strobe.
  // ---------------------------------------------------------------------------
  logic [10:0] sync1_q, sync2_q;
  logic        e_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      e_prev_q <= 1'b0;
    end else begin
      sync1_q  <= {lcd_e, lcd_rs, lcd_rw, sf_d};
      sync2_q  <= sync1_q;
      e_prev_q <= sync2_q[10];
    end
  end

  logic       e_s, rs_s, rw_s;
  logic [7:0] d_s;
  logic       e_fall, wr_cyc;

  assign e_s    = sync2_q[10];
  assign rs_s   = sync2_q[9];
  assign rw_s   = sync2_q[8];
  assign d_s    = sync2_q[7:0];
  assign e_fall = e_prev_q & ~e_s;
  assign wr_cyc = e_fall & ~rw_s;

`ifdef LCD_BUSY_FLAG_EN
  logic rd_cyc;
  assign rd_cyc = e_fall & rw_s;
`endif

  // ---------------------------------------------------------------------------
  // State and registers
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    fill_q, fill_d;
  logic [6:0]    addr_q, addr_d;
  logic          id_q, id_d;
  logic          disp_q, disp_d;
  logic          err_q, err_d;
  logic [7:0]    rd_data_q;

  logic [7:0]    mem_q [32];
  logic          mem_we;
  logic [4:0]    mem_waddr;
  logic [7:0]    mem_wdata;

  logic          ddram_ok;

  // Only the two visible 16-character windows are legal DDRAM targets.
  assign ddram_ok = (d_s[6:4] == 3'b000) || (d_s[6:4] == 3'b100);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    addr_d    = addr_q;
    id_d      = id_q;
    disp_d    = disp_q;
    err_d     = err_q;
    mem_we    = 1'b0;
    mem_waddr = fill_q;
    mem_wdata = SPACE_CHAR;

    // A rejected write does not extend CLEAR/BUSY; it only raises the flag.
    if (wr_cyc && (state_q != ST_IDLE)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = fill_q;
        mem_wdata = SPACE_CHAR;
        if (fill_q == 5'd31) begin
          state_d = ST_BUSY;
          cnt_d   = CLEAR_LOAD;
        end else begin
          fill_d = fill_q + 5'd1;
        end
      end

      ST_BUSY: begin
        // Terminal count at 1 so the state lasts exactly the loaded number of
        // clocks; the <= also covers a zero load.
        if (cnt_q <= CNT_ONE) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      ST_IDLE: begin
        if (wr_cyc) begin
          if (rs_s) begin
            mem_we    = 1'b1;
            mem_waddr = addr_map(addr_q);
            mem_wdata = d_s;
            addr_d    = addr_step(addr_q, id_q);
            state_d   = ST_BUSY;
            cnt_d     = BUSY_LOAD;
          end else if (d_s == 8'h01) begin
            addr_d  = 7'h00;
            id_d    = 1'b1;
            fill_d  = 5'd0;
            state_d = ST_CLEAR;
          end else begin
            // Commands decode on their highest set bit.
            casez (d_s)
              8'b1???_????: addr_d = ddram_ok ? d_s[6:0] : 7'h00;
              8'b01??_????: begin end
              8'b001?_????: begin end
              8'b0001_????: begin
                // d[3]=1 is a display shift, which the mirror does not model.
                if (!d_s[3]) begin
                  addr_d = addr_step(addr_q, d_s[2]);
                end
              end
              8'b0000_1???: disp_d = d_s[2];
              8'b0000_01??: id_d   = d_s[1];
              8'b0000_001?: addr_d = 7'h00;
              default:      begin end
            endcase
            state_d = ST_BUSY;
            cnt_d   = BUSY_LOAD;
          end
        end
`ifdef LCD_BUSY_FLAG_EN
        // A data read advances the counter like a data write would; reads
        // arriving while busy leave the counter alone.
        else if (rd_cyc && rs_s) begin
          addr_d = addr_step(addr_q, id_q);
        end
`endif
      end

      default: begin
        state_d = ST_CLEAR;
        fill_d  = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      cnt_q     <= '0;
      fill_q    <= 5'd0;
      addr_q    <= 7'h00;
      id_q      <= 1'b1;
      disp_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
      rd_data_q <= mem_q[rd_addr];
    end
  end

  // Mirror storage has no reset; the CLEAR fill that follows every reset
  // initialises it.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign display_on  = disp_q;
  assign addr_cnt    = addr_q;
  assign err_overrun = err_q;
  assign rd_data     = rd_data_q;

  // ---------------------------------------------------------------------------
  // Optional bus read-back
  // ---------------------------------------------------------------------------
`ifdef LCD_BUSY_FLAG_EN
  logic       oe_q;
  logic [7:0] dout_q;

  // Registered from the synced strobe so the drive ends 3 clk after the raw
  // strobe falls, together with the cycle being acted on.
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q   <= 1'b0;
      dout_q <= 8'h00;
    end else begin
      oe_q   <= e_s & rw_s;
      dout_q <= rs_s ? mem_q[addr_map(addr_q)] : {busy, addr_q};
    end
  end

  assign sf_d_oe  = oe_q;
  assign sf_d_out = dout_q;
`else
  assign sf_d_oe  = 1'b0;
  assign sf_d_out = 8'h00;
`endif

endmodule

// File: tb/tb_lcd_bus_responder.sv
module tb_lcd_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       lcd_e, lcd_rs, lcd_rw;
  logic [7:0] sf_d;
  logic [7:0] sf_d_out;
  logic       sf_d_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy, display_on, err_overrun;
  logic [6:0] addr_cnt;

  lcd_bus_responder #(.BUSY_CYCLES(16), .CLEAR_BUSY_CYCLES(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .lcd_e      (lcd_e),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .sf_d       (sf_d),
    .sf_d_out   (sf_d_out),
    .sf_d_oe    (sf_d_oe),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .busy       (busy),
    .display_on (display_on),
    .addr_cnt   (addr_cnt),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  localparam int SEL_BUSY = 0;
  localparam int SEL_ADDR = 1;
  localparam int SEL_DISP = 2;
  localparam int SEL_ERR  = 3;
  localparam int SEL_RD   = 4;
  localparam int SEL_OE   = 5;
  localparam int SEL_SFD  = 6;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Monitor: everything pushed since the last falling edge is compared here.
  always @(negedge clk) begin
    exp_t       it;
    logic [7:0] act;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      case (it.sel)
        SEL_BUSY: act = {7'd0, busy};
        SEL_ADDR: act = {1'b0, addr_cnt};
        SEL_DISP: act = {7'd0, display_on};
        SEL_ERR:  act = {7'd0, err_overrun};
        SEL_RD:   act = rd_data;
        SEL_OE:   act = {7'd0, sf_d_oe};
        default:  act = sf_d_out;
      endcase
      n_cmp++;
      if (act !== it.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%02h expected 0x%02h", it.name, act, it.exp);
      end
    end
  end

  task automatic expect_sig(input string nm, input int sel, input logic [7:0] e);
    exp_t it;
    it.name = nm;
    it.sel  = sel;
    it.exp  = e;
    sb_q.push_back(it);
  endtask

  task automatic expect_rd(input string nm, input logic [4:0] a, input logic [7:0] e);
    rd_addr = a;
    @(posedge clk); #1;
    expect_sig(nm, SEL_RD, e);
  endtask

  task automatic chk_val(input string nm, input int act, input int e);
    n_cmp++;
    if (act != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, e);
    end
  endtask

  // One controller cycle: bus and strobe set together, strobe held elen clk,
  // then 4 clk so the responder has acted before returning.
  task automatic bus_cyc(input logic rs, input logic rw, input logic [7:0] d, input int elen);
    lcd_rs = rs;
    lcd_rw = rw;
    sf_d   = d;
    lcd_e  = 1'b1;
    repeat (elen) @(posedge clk);
    #1 lcd_e = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy && n < 300);
    if (busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: busy still 1 after %0d clk", n);
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    int n;
    bus_cyc(rs, 1'b0, d, 2);
    wait_idle(n);
  endtask

  task automatic rd_hold_begin(input logic rs);
    lcd_rs = rs;
    lcd_rw = 1'b1;
    lcd_e  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rd_hold_end();
    lcd_e = 1'b0;
    repeat (4) @(posedge clk);
    #1 lcd_rw = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; lcd_e = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
    sf_d = 8'h00; rd_addr = 5'd0;

    // Reset state
    repeat (2) @(posedge clk); #1;
    expect_sig("rst_busy", SEL_BUSY, 8'h01);
    expect_sig("rst_addr", SEL_ADDR, 8'h00);
    expect_sig("rst_disp", SEL_DISP, 8'h00);
    expect_sig("rst_err",  SEL_ERR,  8'h00);
    expect_sig("rst_rd",   SEL_RD,   8'h00);
    expect_sig("rst_oe",   SEL_OE,   8'h00);
    expect_sig("rst_sfd",  SEL_SFD,  8'h00);
    rst = 1'b0;

    // Busy for exactly 32 fill + 64 busy clocks
    repeat (95) @(posedge clk); #1;
    expect_sig("busy_clk95", SEL_BUSY, 8'h01);
    @(posedge clk); #1;
    expect_sig("busy_clk96", SEL_BUSY, 8'h00);

    for (int i = 0; i < 32; i++) expect_rd("clear_fill", 5'(i), 8'h20);
    expect_sig("idle_addr", SEL_ADDR, 8'h00);
    expect_sig("idle_disp", SEL_DISP, 8'h00);

    // Display on, first character
    wr(1'b0, 8'h0C);
    wr(1'b1, 8'h41);
    expect_sig("disp_on", SEL_DISP, 8'h01);
    expect_sig("addr_after_A", SEL_ADDR, 8'h01);
    expect_rd("mirror0_A", 5'd0, 8'h41);

    // Line 1 end wraps to line 2
    wr(1'b0, 8'h8F);
    wr(1'b1, 8'h31);
    wr(1'b1, 8'h32);
    expect_rd("mirror15", 5'd15, 8'h31);
    expect_rd("mirror16", 5'd16, 8'h32);
    expect_sig("addr_0x41", SEL_ADDR, 8'h41);

    // Decrement from 0x00 wraps to 0x4F
    wr(1'b0, 8'h04);
    wr(1'b0, 8'h80);
    wr(1'b1, 8'h58);
    expect_rd("mirror0_X", 5'd0, 8'h58);
    expect_sig("addr_dec_wrap", SEL_ADDR, 8'h4F);

    // Overrun: home, then a data cycle acted on 5 clk later
    bus_cyc(1'b0, 1'b0, 8'h02, 1);
    bus_cyc(1'b1, 1'b0, 8'h77, 1);
    repeat (9) @(posedge clk); #1;
    expect_sig("ovr_busy_hi", SEL_BUSY, 8'h01);
    @(posedge clk); #1;
    expect_sig("ovr_busy_lo", SEL_BUSY, 8'h00);
    expect_sig("ovr_err", SEL_ERR, 8'h01);
    expect_sig("ovr_addr", SEL_ADDR, 8'h00);
    expect_rd("ovr_mirror0", 5'd0, 8'h58);

    // Cursor shifts and ignored display shift
    wr(1'b0, 8'h14);
    expect_sig("shift_right", SEL_ADDR, 8'h01);
    wr(1'b0, 8'h10);
    expect_sig("shift_left", SEL_ADDR, 8'h00);
    wr(1'b0, 8'h10);
    expect_sig("shift_left_wrap", SEL_ADDR, 8'h4F);
    wr(1'b0, 8'h18);
    expect_sig("disp_shift_ign", SEL_ADDR, 8'h4F);

    // Out-of-window DDRAM address, last cell, increment wrap 0x4F -> 0x00
    wr(1'b0, 8'h90);
    expect_sig("ddram_invalid", SEL_ADDR, 8'h00);
    wr(1'b0, 8'h06);
    wr(1'b0, 8'hCF);
    expect_sig("ddram_0x4F", SEL_ADDR, 8'h4F);
    wr(1'b1, 8'h5A);
    expect_rd("mirror31", 5'd31, 8'h5A);
    expect_sig("addr_inc_wrap", SEL_ADDR, 8'h00);

    // Busy-flag read: answered only in the feature build, never busy/err
    rd_hold_begin(1'b0);
`ifdef LCD_BUSY_FLAG_EN
    expect_sig("rd_oe", SEL_OE, 8'h01);
    expect_sig("rd_sfd", SEL_SFD, 8'h00);
`else
    expect_sig("rd_oe", SEL_OE, 8'h00);
`endif
    rd_hold_end();
    expect_sig("rd_busy", SEL_BUSY, 8'h00);
    expect_sig("rd_err", SEL_ERR, 8'h01);
    expect_sig("rd_addr_cnt", SEL_ADDR, 8'h00);
    expect_sig("rd_oe_off", SEL_OE, 8'h00);

    // Clear restores spaces and increment mode
    wr(1'b0, 8'h04);
    bus_cyc(1'b0, 1'b0, 8'h01, 2);
    wait_idle(n);
    expect_rd("clr_m0", 5'd0, 8'h20);
    expect_rd("clr_m16", 5'd16, 8'h20);
    expect_rd("clr_m31", 5'd31, 8'h20);
    expect_sig("clr_addr", SEL_ADDR, 8'h00);
    expect_sig("clr_disp", SEL_DISP, 8'h01);
    wr(1'b1, 8'h33);
    expect_rd("clr_m0_wr", 5'd0, 8'h33);
    expect_sig("clr_id_inc", SEL_ADDR, 8'h01);

`ifdef LCD_BUSY_FLAG_EN
    wr(1'b0, 8'hC3);
    rd_hold_begin(1'b0);
    expect_sig("bf_oe", SEL_OE, 8'h01);
    expect_sig("bf_sfd", SEL_SFD, 8'h43);
    rd_hold_end();
    bus_cyc(1'b0, 1'b0, 8'h02, 2);
    rd_hold_begin(1'b0);
    expect_sig("bf_busy_sfd", SEL_SFD, 8'h80);
    rd_hold_end();
    wait_idle(n);
`endif

    // Reset mid-BUSY restarts the whole sequence
    bus_cyc(1'b1, 1'b0, 8'h44, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    expect_sig("rst2_busy", SEL_BUSY, 8'h01);
    expect_sig("rst2_err", SEL_ERR, 8'h00);
    expect_sig("rst2_disp", SEL_DISP, 8'h00);
    expect_sig("rst2_addr", SEL_ADDR, 8'h00);
    rst = 1'b0;
    wait_idle(n);
    chk_val("rst2_busy_len", n, 96);
    expect_rd("rst2_m0", 5'd0, 8'h20);

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
